// File: rtl/watch_pkg.sv
// Shared definitions for the multi-mode watch: mode encoding, BCD digit width
// and a single-digit BCD increment helper.
package watch_pkg;

  typedef enum logic [1:0] {
    WATCH  = 2'd0,
    CHANGE = 2'd1,
    CHRONO = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;

  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with ripple carry, synchronous clear and a
// single-digit increment (mod 10, no carry) used for manual time setting.
module bcd_counter
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inc,
  input  logic                          clr,
  input  logic                          ld_en,
  input  logic [SEL_W-1:0]              ld_idx,
  output logic [DIGIT_W*NUM_DIGITS-1:0] value
);

  logic [DIGIT_W*NUM_DIGITS-1:0] value_q, value_d;
  logic                          carry;

  // Clear beats a digit load, which beats a counting increment.
  always_comb begin
    value_d = value_q;
    carry   = 1'b0;
    if (clr) begin
      value_d = '0;
    end else if (ld_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (ld_idx == SEL_W'(i)) begin
          value_d[i*DIGIT_W +: DIGIT_W] = bcd_inc(value_q[i*DIGIT_W +: DIGIT_W]);
        end
      end
    end else if (inc) begin
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          value_d[i*DIGIT_W +: DIGIT_W] = bcd_inc(value_q[i*DIGIT_W +: DIGIT_W]);
          carry = (value_q[i*DIGIT_W +: DIGIT_W] == 4'd9);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/watch_fsm_multi.sv
// Three-mode digital watch: time keeping, time setting and stopwatch.
// Define WATCH_LAP_EN to add a lap-hold display freeze in stopwatch mode.
//
// state  | meaning
// WATCH  | show time, time counts on tick
// CHANGE | time frozen; start selects digit, adjust bumps selected digit
// CHRONO | show stopwatch; start runs/stops, adjust clears (or laps)
module watch_fsm_multi
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          timer_tick,
  input  logic                          btn_mode,
  input  logic                          btn_start,
  input  logic                          btn_adjust,
  output logic [DIGIT_W*NUM_DIGITS-1:0] display_out,
  output logic                          status_watch_out,
  output logic                          status_change_out,
  output logic                          status_chrono_out,
  output logic [SEL_W-1:0]              sel_digit_out,
  output logic                          chrono_running_out
);

  localparam int               VAL_W    = DIGIT_W * NUM_DIGITS;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               running_q, running_d;
  logic [2:0]         btn_prev_q, btn_prev_d;
  logic               armed_q, armed_d;
  logic [VAL_W-1:0]   display_q, display_d;

  logic [2:0]         btn_edge;
  logic               mode_edge, start_edge, adj_edge;
  logic               w_inc, w_ld, c_inc, c_clr;
  logic [VAL_W-1:0]   watch_val, chrono_val;

`ifdef WATCH_LAP_EN
  logic               lap_q, lap_d;
  logic [VAL_W-1:0]   lap_val_q, lap_val_d;
`endif

  always_comb begin
    btn_prev_d = {btn_adjust, btn_start, btn_mode};
    armed_d    = 1'b1;
    // The first cycle after reset only samples levels, so a button that is
    // already held at release acts only on its next rising edge.
    btn_edge   = armed_q ? (btn_prev_d & ~btn_prev_q) : 3'b000;
    mode_edge  = btn_edge[0];
    start_edge = btn_edge[1];
    adj_edge   = btn_edge[2];

    state_d   = state_q;
    sel_d     = sel_q;
    running_d = running_q;
    w_inc     = 1'b0;
    w_ld      = 1'b0;
    c_clr     = 1'b0;
    c_inc     = timer_tick & running_q;

    case (state_q)
      WATCH: begin
        if (mode_edge) state_d = CHANGE;
        w_inc = timer_tick;
      end
      CHANGE: begin
        if (mode_edge) state_d = CHRONO;
        if (start_edge) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        w_ld = adj_edge;
      end
      CHRONO: begin
        if (mode_edge) state_d = WATCH;
        w_inc = timer_tick;
        if (start_edge) running_d = ~running_q;
        c_clr = adj_edge & ~running_q;
      end
      default: state_d = WATCH;
    endcase

`ifdef WATCH_LAP_EN
    lap_d     = lap_q;
    lap_val_d = lap_val_q;
    if ((state_q == CHRONO) && adj_edge && running_q) begin
      lap_d = ~lap_q;
      if (!lap_q) lap_val_d = chrono_val;
    end
    if ((state_d != CHRONO) || (running_q && !running_d)) lap_d = 1'b0;

    display_d = (state_q != CHRONO) ? watch_val :
                (lap_q ? lap_val_q : chrono_val);
`else
    display_d = (state_q == CHRONO) ? chrono_val : watch_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WATCH;
      sel_q      <= '0;
      running_q  <= 1'b0;
      btn_prev_q <= '0;
      armed_q    <= 1'b0;
      display_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      running_q  <= running_d;
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
      display_q  <= display_d;
    end
  end

`ifdef WATCH_LAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q     <= 1'b0;
      lap_val_q <= '0;
    end else begin
      lap_q     <= lap_d;
      lap_val_q <= lap_val_d;
    end
  end
`endif

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_watch (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_inc),
    .clr    (1'b0),
    .ld_en  (w_ld),
    .ld_idx (sel_q),
    .value  (watch_val)
  );

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS), .SEL_W(SEL_W)) u_chrono (
    .clk    (clk),
    .rst    (rst),
    .inc    (c_inc),
    .clr    (c_clr),
    .ld_en  (1'b0),
    .ld_idx ('0),
    .value  (chrono_val)
  );

  assign display_out        = display_q;
  assign status_change_out  = (state_q == CHANGE);
  assign status_chrono_out  = (state_q == CHRONO);
  assign status_watch_out   = ~(status_change_out | status_chrono_out);
  assign sel_digit_out      = sel_q;
  assign chrono_running_out = running_q;

endmodule

// File: tb/tb_watch_fsm_multi.sv
// Bench for watch_fsm_multi (NUM_DIGITS=2): directed scenarios plus random
// stimulus, compared every cycle against an integer-level watch model.
module tb_watch_fsm_multi;

  localparam int ND  = 2;
  localparam int SW  = 3;
  localparam int MOD = 10 ** ND;

  bit               clk;
  logic             rst, timer_tick, btn_mode, btn_start, btn_adjust;
  logic [4*ND-1:0]  display_out;
  logic             st_watch, st_change, st_chrono;
  logic [SW-1:0]    sel_digit;
  logic             running;

  int n_tests, n_fail;

  // Model: plain integers for the two clocks, mode as 0/1/2.
  int              m_mode, m_watch, m_chrono, m_sel, m_lapv;
  bit              m_run, m_lap, m_armed;
  bit [2:0]        m_prev;
  logic [4*ND-1:0] m_disp;

  watch_fsm_multi #(.NUM_DIGITS(ND), .SEL_W(SW)) dut (
    .clk                (clk),
    .rst                (rst),
    .timer_tick         (timer_tick),
    .btn_mode           (btn_mode),
    .btn_start          (btn_start),
    .btn_adjust         (btn_adjust),
    .display_out        (display_out),
    .status_watch_out   (st_watch),
    .status_change_out  (st_change),
    .status_chrono_out  (st_chrono),
    .sel_digit_out      (sel_digit),
    .chrono_running_out (running)
  );

  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4*ND-1:0] shown();
    if (m_mode != 2) return to_bcd(m_watch);
    return m_lap ? to_bcd(m_lapv) : to_bcd(m_chrono);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_watch = 0; m_chrono = 0; m_sel = 0; m_lapv = 0;
    m_run = 0; m_lap = 0; m_armed = 0; m_prev = 3'b000; m_disp = '0;
  endtask

  task automatic model_step();
    bit [2:0] lv, e;
    int old_mode, old_chrono, place, d;
    bit old_run;
    logic [4*ND-1:0] nd;
    if (rst) begin
      model_reset();
      return;
    end
    nd = shown();
    lv = {btn_adjust, btn_start, btn_mode};
    e  = m_armed ? (lv & ~m_prev) : 3'b000;
    m_prev = lv;
    m_armed = 1;
    old_mode = m_mode; old_run = m_run; old_chrono = m_chrono;
    if (timer_tick && old_mode != 1) m_watch = (m_watch + 1) % MOD;
    if (old_mode == 1 && e[2]) begin
      place = 10 ** m_sel;
      d = (m_watch / place) % 10;
      m_watch = m_watch + (((d + 1) % 10) - d) * place;
    end
    if (old_mode == 1 && e[1]) m_sel = (m_sel + 1) % ND;
    if (old_mode == 2 && e[2] && !old_run) m_chrono = 0;
    else if (timer_tick && old_run) m_chrono = (m_chrono + 1) % MOD;
`ifdef WATCH_LAP_EN
    if (old_mode == 2 && e[2] && old_run) begin
      if (!m_lap) m_lapv = old_chrono;
      m_lap = !m_lap;
    end
`endif
    if (old_mode == 2 && e[1]) m_run = !m_run;
    if (e[0]) m_mode = (m_mode + 1) % 3;
    if (m_mode != 2 || (old_run && !m_run)) m_lap = 0;
    m_disp = nd;
  endtask

  always @(negedge clk) begin
    n_tests++;
    if (display_out !== m_disp || st_watch !== (m_mode == 0) ||
        st_change !== (m_mode == 1) || st_chrono !== (m_mode == 2) ||
        sel_digit !== SW'(m_sel) || running !== m_run) begin
      n_fail++;
      $display("FAIL cycle t=%0t disp=%h exp=%h status=%b%b%b exp_mode=%0d sel=%0d exp=%0d run=%b exp=%b",
               $time, display_out, m_disp, st_watch, st_change, st_chrono, m_mode,
               sel_digit, m_sel, running, m_run);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit t, input bit m, input bit s, input bit a);
    timer_tick = t; btn_mode = m; btn_start = s; btn_adjust = a;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic press_mode();  cycle(0, 1, 0, 0); idle(1); endtask
  task automatic press_start(); cycle(0, 0, 1, 0); idle(1); endtask
  task automatic press_adj();   cycle(0, 0, 0, 1); idle(1); endtask

  initial begin
    rst = 1; timer_tick = 0; btn_mode = 0; btn_start = 0; btn_adjust = 0;
    model_reset();
    idle(3);
    chk("reset_disp", 32'(display_out), 32'h0);
    chk("reset_status", {29'd0, st_watch, st_change, st_chrono}, 32'b100);
    chk("reset_sel", 32'(sel_digit), 32'd0);
    chk("reset_run", 32'(running), 32'd0);
    rst = 0;
    idle(2);

    // 100 ticks in WATCH: 99 -> 0x99, 100th wraps to 0x00
    for (int i = 0; i < 99; i++) cycle(1, 0, 0, 0);
    idle(1);
    chk("watch_99", 32'(display_out), 32'h99);
    cycle(1, 0, 0, 0);
    idle(1);
    chk("watch_wrap", 32'(display_out), 32'h00);

    // CHANGE: select tens digit, bump it three times, ticks frozen
    press_mode();
    press_start();
    press_adj(); press_adj(); press_adj();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    idle(1);
    chk("change_status", 32'(st_change), 32'd1);
    chk("change_sel", 32'(sel_digit), 32'd1);
    chk("change_tens", 32'(display_out), 32'h30);

    // CHRONO: run 5 ticks, stop, clear
    press_mode();
    chk("chrono_status", 32'(st_chrono), 32'd1);
    chk("chrono_disp0", 32'(display_out), 32'h00);
    press_start();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    press_start();
    chk("chrono_5", 32'(display_out), 32'h05);
    chk("chrono_stopped", 32'(running), 32'd0);
    press_adj();
    idle(1);
    chk("chrono_clear", 32'(display_out), 32'h00);
    press_mode();
    idle(1);
    chk("watch_plus5", 32'(display_out), 32'h35);

    // Held start gives one toggle
    press_mode(); press_mode();
    for (int i = 0; i < 1000; i++) cycle(0, 0, 1, 0);
    idle(1);
    chk("held_start", 32'(running), 32'd1);
    press_start();
    chk("restop", 32'(running), 32'd0);
    press_mode(); press_mode();
    press_start();
    chk("sel_wrap", 32'(sel_digit), 32'd0);
    cycle(0, 1, 1, 0);
    idle(1);
    chk("same_cycle_sel", 32'(sel_digit), 32'd1);
    chk("same_cycle_mode", 32'(st_chrono), 32'd1);

    // Reset mid-run, start held through reset release
    press_start();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    btn_start = 1;
    #2 rst = 1;
    #1;
    chk("rst_disp", 32'(display_out), 32'h0);
    chk("rst_status", {29'd0, st_watch, st_change, st_chrono}, 32'b100);
    chk("rst_sel", 32'(sel_digit), 32'd0);
    chk("rst_run", 32'(running), 32'd0);
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0);
    idle(1);
    chk("held_after_rst_run", 32'(running), 32'd0);
    chk("held_after_rst_disp", 32'(display_out), 32'h04);

    // Lap hold (or adjust ignored while running)
    press_mode(); press_mode();
    press_start();
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
    press_adj();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    idle(1);
`ifdef WATCH_LAP_EN
    chk("lap_hold", 32'(display_out), 32'h07);
`else
    chk("adj_ignored_running", 32'(display_out), 32'h10);
`endif
    press_adj();
    idle(1);
    chk("lap_release", 32'(display_out), 32'h10);
    chk("lap_still_running", 32'(running), 32'd1);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 499) == 0) rst = 1;
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    rst = 0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
